// File: rtl/nv_nvdla_cmac_a2cacc_arb.sv
// Merges two valid-only CMAC->CACC result streams into one valid/ready accumulator port.
// Each source is buffered in a small FIFO; a round-robin arbiter with stall-hold picks the head.
module nv_nvdla_cmac_a2cacc_arb #(
  parameter int unsigned ATOMK_HALF   = 8,
  parameter int unsigned RESULT_WIDTH = 19,
  parameter int unsigned PD_WIDTH     = 9,
  parameter int unsigned DEPTH        = 4
) (
  input  logic                               nvdla_core_clk,
  input  logic                               nvdla_core_rst,
  input  logic                               a_pvld,
  input  logic [ATOMK_HALF-1:0]              a_mask,
  input  logic                               a_mode,
  input  logic [ATOMK_HALF*RESULT_WIDTH-1:0] a_data,
  input  logic [PD_WIDTH-1:0]                a_pd,
  input  logic                               b_pvld,
  input  logic [ATOMK_HALF-1:0]              b_mask,
  input  logic                               b_mode,
  input  logic [ATOMK_HALF*RESULT_WIDTH-1:0] b_data,
  input  logic [PD_WIDTH-1:0]                b_pd,
  output logic                               dst_pvld,
  input  logic                               dst_prdy,
  output logic [ATOMK_HALF-1:0]              dst_mask,
  output logic                               dst_mode,
  output logic [ATOMK_HALF*RESULT_WIDTH-1:0] dst_data,
  output logic [PD_WIDTH-1:0]                dst_pd,
  output logic                               dst_src,
  output logic [$clog2(DEPTH):0]             a_cnt,
  output logic [$clog2(DEPTH):0]             b_cnt,
  output logic [1:0]                         ovf_err
);

  localparam int unsigned DATA_W  = ATOMK_HALF * RESULT_WIDTH;
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = ATOMK_HALF + 1 + DATA_W + PD_WIDTH;

  logic [ENTRY_W-1:0] mem [2][DEPTH];
  logic [ENTRY_W-1:0] push_entry [2];
  logic [PTR_W-1:0]   wr_ptr [2];
  logic [PTR_W-1:0]   rd_ptr [2];
  logic [CNT_W-1:0]   cnt [2];
  logic [1:0]         push_vld;
  logic [1:0]         not_empty;
  logic [1:0]         full;
  logic [1:0]         pop;
  logic [1:0]         wr_en;
  logic               rr;
  logic               held;
  logic               held_src;
  logic               grant_b;
  logic [ENTRY_W-1:0] head;
  logic [DATA_W-1:0]  head_data;

  assign push_vld      = {b_pvld, a_pvld};
  assign push_entry[0] = {a_mask, a_mode, a_data, a_pd};
  assign push_entry[1] = {b_mask, b_mode, b_data, b_pd};
  assign a_cnt         = cnt[0];
  assign b_cnt         = cnt[1];

  // Arbitration on registered FIFO state; a stalled grant stays on its source until popped.
  always_comb begin
    not_empty = '0;
    full      = '0;
    pop       = '0;
    wr_en     = '0;
    grant_b   = 1'b0;
    dst_pvld  = 1'b0;

    not_empty[0] = (cnt[0] != '0);
    not_empty[1] = (cnt[1] != '0);
    full[0]      = (cnt[0] == CNT_W'(DEPTH));
    full[1]      = (cnt[1] == CNT_W'(DEPTH));
    dst_pvld     = not_empty[0] | not_empty[1];
    grant_b      = held ? held_src : (not_empty[1] & (~not_empty[0] | rr));

    pop[0]   = dst_pvld & dst_prdy & ~grant_b;
    pop[1]   = dst_pvld & dst_prdy & grant_b;
    wr_en[0] = push_vld[0] & (~full[0] | pop[0]);
    wr_en[1] = push_vld[1] & (~full[1] | pop[1]);
  end

  // Granted head with masked-off lanes forced to zero; everything zero when idle.
  always_comb begin
    head      = mem[grant_b][rd_ptr[grant_b]];
    head_data = '0;
    dst_mask  = '0;
    dst_mode  = 1'b0;
    dst_data  = '0;
    dst_pd    = '0;
    dst_src   = 1'b0;
    if (dst_pvld) begin
      {dst_mask, dst_mode, head_data, dst_pd} = head;
      dst_src = grant_b;
      for (int unsigned k = 0; k < ATOMK_HALF; k++) begin
        dst_data[k*RESULT_WIDTH +: RESULT_WIDTH] =
          dst_mask[k] ? head_data[k*RESULT_WIDTH +: RESULT_WIDTH] : '0;
      end
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    for (int s = 0; s < 2; s++) begin
      if (wr_en[s]) begin
        mem[s][wr_ptr[s]] <= push_entry[s];
      end
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      for (int s = 0; s < 2; s++) begin
        wr_ptr[s] <= '0;
        rd_ptr[s] <= '0;
        cnt[s]    <= '0;
      end
      rr       <= 1'b0;
      held     <= 1'b0;
      held_src <= 1'b0;
      ovf_err  <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (wr_en[s]) begin
          wr_ptr[s] <= wr_ptr[s] + PTR_W'(1);
        end
        if (pop[s]) begin
          rd_ptr[s] <= rd_ptr[s] + PTR_W'(1);
        end
        cnt[s] <= cnt[s] + CNT_W'(wr_en[s]) - CNT_W'(pop[s]);
        // A push into a full FIFO that is not draining this cycle is lost.
        if (push_vld[s] & ~wr_en[s]) begin
          ovf_err[s] <= 1'b1;
        end
      end
      if (|pop) begin
        rr <= ~grant_b;
      end
      held     <= dst_pvld & ~dst_prdy;
      held_src <= grant_b;
    end
  end

endmodule

// File: tb/tb_nv_nvdla_cmac_a2cacc_arb.sv
// Bench for the two-source CMAC->CACC arbiter: directed table, corner sequences, random vs queue model.
module tb_nv_nvdla_cmac_a2cacc_arb;

  localparam int unsigned AH    = 8;
  localparam int unsigned RW    = 19;
  localparam int unsigned PW    = 9;
  localparam int          DEPTH = 4;
  localparam int unsigned DW    = AH * RW;

  typedef struct packed {
    logic [AH-1:0] mask;
    logic          mode;
    logic [DW-1:0] data;
    logic [PW-1:0] pd;
  } beat_t;

  typedef struct {
    bit        rst;
    bit        av;
    logic [7:0] amask;
    logic [8:0] apd;
    int        atag;
    bit        bv;
    logic [7:0] bmask;
    logic [8:0] bpd;
    int        btag;
    bit        prdy;
    bit        e_pvld;
    bit        e_src;
    logic [8:0] e_pd;
    int        e_acnt;
    int        e_bcnt;
    logic [1:0] e_ovf;
    int        e_l3;
    int        e_l4;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_pvld = 1'b0, b_pvld = 1'b0, dst_prdy = 1'b0;
  logic [AH-1:0] a_mask = '0, b_mask = '0;
  logic          a_mode = 1'b0, b_mode = 1'b0;
  logic [DW-1:0] a_data = '0, b_data = '0;
  logic [PW-1:0] a_pd = '0, b_pd = '0;
  logic          dst_pvld, dst_mode, dst_src;
  logic [AH-1:0] dst_mask;
  logic [DW-1:0] dst_data;
  logic [PW-1:0] dst_pd;
  logic [2:0]    a_cnt, b_cnt;
  logic [1:0]    ovf_err;

  always #5 clk = ~clk;

  nv_nvdla_cmac_a2cacc_arb #(
    .ATOMK_HALF(AH), .RESULT_WIDTH(RW), .PD_WIDTH(PW), .DEPTH(DEPTH)
  ) dut (
    .nvdla_core_clk(clk), .nvdla_core_rst(rst),
    .a_pvld(a_pvld), .a_mask(a_mask), .a_mode(a_mode), .a_data(a_data), .a_pd(a_pd),
    .b_pvld(b_pvld), .b_mask(b_mask), .b_mode(b_mode), .b_data(b_data), .b_pd(b_pd),
    .dst_pvld(dst_pvld), .dst_prdy(dst_prdy), .dst_mask(dst_mask), .dst_mode(dst_mode),
    .dst_data(dst_data), .dst_pd(dst_pd), .dst_src(dst_src),
    .a_cnt(a_cnt), .b_cnt(b_cnt), .ovf_err(ovf_err)
  );

  // Reference model: one queue per source, a round-robin preference and a remembered stalled side.
  beat_t qa[$];
  beat_t qb[$];
  bit    rr_m;
  bit [1:0] ovf_m;
  int    hold_m;
  int    n_chk;
  int    n_err;
  vec_t  tbl [15];
  beat_t zb;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic beat_t mk_beat(input int tag, input logic [7:0] mask, input logic [8:0] pd);
    beat_t b;
    b      = '0;
    b.mask = mask;
    b.mode = 1'(tag & 1);
    b.pd   = pd;
    for (int k = 0; k < int'(AH); k++) b.data[k*RW +: RW] = RW'(tag * 16 + k + 1);
    return b;
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    b.mask = AH'($urandom());
    b.mode = 1'($urandom());
    b.data = DW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    b.pd   = PW'($urandom());
    return b;
  endfunction

  function automatic beat_t masked(input beat_t b);
    beat_t r;
    r = b;
    for (int k = 0; k < int'(AH); k++) if (!b.mask[k]) r.data[k*RW +: RW] = '0;
    return r;
  endfunction

  function automatic int pick();
    if (hold_m >= 0) return hold_m;
    if (qa.size() != 0 && qb.size() != 0) return rr_m ? 1 : 0;
    if (qa.size() != 0) return 0;
    if (qb.size() != 0) return 1;
    return -1;
  endfunction

  task automatic model_check();
    int    s;
    beat_t e;
    s = pick();
    e = '0;
    if (s == 0) e = masked(qa[0]);
    if (s == 1) e = masked(qb[0]);
    chk("m_pvld", dst_pvld, s >= 0);
    chk("m_src",  dst_src,  s == 1);
    chk("m_mask", dst_mask, e.mask);
    chk("m_mode", dst_mode, e.mode);
    chk("m_data", dst_data, e.data);
    chk("m_pd",   dst_pd,   e.pd);
    chk("m_acnt", a_cnt,    qa.size());
    chk("m_bcnt", b_cnt,    qb.size());
    chk("m_ovf",  ovf_err,  ovf_m);
  endtask

  task automatic model_step(input bit r, input bit av, input beat_t ab, input bit bv,
                            input beat_t bb, input bit prdy);
    int s;
    s = pick();
    if (r) begin
      qa.delete();
      qb.delete();
      rr_m   = 1'b0;
      ovf_m  = '0;
      hold_m = -1;
      return;
    end
    if (s >= 0 && prdy) begin
      if (s == 0) void'(qa.pop_front());
      else        void'(qb.pop_front());
      rr_m   = (s == 0);
      hold_m = -1;
    end else begin
      hold_m = s;
    end
    if (av) begin
      if (qa.size() < DEPTH) qa.push_back(ab);
      else                   ovf_m[0] = 1'b1;
    end
    if (bv) begin
      if (qb.size() < DEPTH) qb.push_back(bb);
      else                   ovf_m[1] = 1'b1;
    end
  endtask

  // Drive one cycle's inputs at negedge, check the current outputs, then advance the model.
  task automatic cycle(input bit r, input bit av, input beat_t ab, input bit bv,
                       input beat_t bb, input bit prdy);
    @(negedge clk);
    rst      = r;
    a_pvld   = av;
    a_mask   = ab.mask;
    a_mode   = ab.mode;
    a_data   = ab.data;
    a_pd     = ab.pd;
    b_pvld   = bv;
    b_mask   = bb.mask;
    b_mode   = bb.mode;
    b_data   = bb.data;
    b_pd     = bb.pd;
    dst_prdy = prdy;
    #1;
    model_check();
    model_step(r, av, ab, bv, bb, prdy);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_chk  = 0;
    n_err  = 0;
    zb     = '0;
    rr_m   = 1'b0;
    ovf_m  = '0;
    hold_m = -1;
    repeat (2) @(posedge clk);

    // rst,av,amask,apd,atag, bv,bmask,bpd,btag, prdy | pvld,src,pd,acnt,bcnt,ovf,lane3,lane4
    tbl[0]  = '{0,1,8'h0F,9'h1A5,0, 0,8'h00,9'h000,0, 1, 0,0,9'h000,0,0,2'b00,0,0};
    tbl[1]  = '{0,0,8'h00,9'h000,0, 0,8'h00,9'h000,0, 0, 1,0,9'h1A5,1,0,2'b00,4,0};
    tbl[2]  = '{0,0,8'h00,9'h000,0, 0,8'h00,9'h000,0, 1, 1,0,9'h1A5,1,0,2'b00,4,0};
    tbl[3]  = '{0,0,8'h00,9'h000,0, 0,8'h00,9'h000,0, 1, 0,0,9'h000,0,0,2'b00,0,0};
    tbl[4]  = '{1,0,8'h00,9'h000,0, 0,8'h00,9'h000,0, 0, 0,0,9'h000,0,0,2'b00,0,0};
    tbl[5]  = '{0,1,8'hFF,9'h011,1, 1,8'hFF,9'h022,2, 1, 0,0,9'h000,0,0,2'b00,0,0};
    tbl[6]  = '{0,1,8'hFF,9'h033,3, 1,8'hFF,9'h044,4, 1, 1,0,9'h011,1,1,2'b00,20,21};
    tbl[7]  = '{0,1,8'hFF,9'h055,5, 1,8'hFF,9'h066,6, 1, 1,1,9'h022,1,2,2'b00,36,37};
    tbl[8]  = '{0,1,8'hFF,9'h077,7, 1,8'hFF,9'h088,8, 1, 1,0,9'h033,2,2,2'b00,52,53};
    tbl[9]  = '{0,0,8'h00,9'h000,0, 0,8'h00,9'h000,0, 1, 1,1,9'h044,2,3,2'b00,68,69};
    tbl[10] = '{0,0,8'h00,9'h000,0, 0,8'h00,9'h000,0, 1, 1,0,9'h055,2,2,2'b00,84,85};
    tbl[11] = '{0,0,8'h00,9'h000,0, 0,8'h00,9'h000,0, 1, 1,1,9'h066,1,2,2'b00,100,101};
    tbl[12] = '{0,0,8'h00,9'h000,0, 0,8'h00,9'h000,0, 1, 1,0,9'h077,1,1,2'b00,116,117};
    tbl[13] = '{0,0,8'h00,9'h000,0, 0,8'h00,9'h000,0, 1, 1,1,9'h088,0,1,2'b00,132,133};
    tbl[14] = '{0,0,8'h00,9'h000,0, 0,8'h00,9'h000,0, 1, 0,0,9'h000,0,0,2'b00,0,0};

    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].rst, tbl[i].av, mk_beat(tbl[i].atag, tbl[i].amask, tbl[i].apd),
            tbl[i].bv, mk_beat(tbl[i].btag, tbl[i].bmask, tbl[i].bpd), tbl[i].prdy);
      chk($sformatf("tbl%0d_pvld", i), dst_pvld, tbl[i].e_pvld);
      chk($sformatf("tbl%0d_src", i),  dst_src,  tbl[i].e_src);
      chk($sformatf("tbl%0d_pd", i),   dst_pd,   tbl[i].e_pd);
      chk($sformatf("tbl%0d_acnt", i), a_cnt,    tbl[i].e_acnt);
      chk($sformatf("tbl%0d_bcnt", i), b_cnt,    tbl[i].e_bcnt);
      chk($sformatf("tbl%0d_ovf", i),  ovf_err,  tbl[i].e_ovf);
      chk($sformatf("tbl%0d_lane3", i), dst_data[3*RW +: RW], tbl[i].e_l3);
      chk($sformatf("tbl%0d_lane4", i), dst_data[4*RW +: RW], tbl[i].e_l4);
    end

    // Overflow: five pushes into a stalled FIFO, the fifth is dropped and flagged.
    cycle(1, 0, zb, 0, zb, 0);
    for (int i = 0; i < 5; i++) cycle(0, 1, mk_beat(10 + i, 8'hFF, 9'(10 + i)), 0, zb, 0);
    cycle(0, 0, zb, 0, zb, 0);
    chk("ovf_acnt", a_cnt, 4);
    chk("ovf_flag", ovf_err, 2'b01);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, zb, 0, zb, 1);
      chk($sformatf("ovf_order%0d", i), dst_pd, 9'(10 + i));
    end
    cycle(0, 0, zb, 0, zb, 1);
    chk("ovf_drained", dst_pvld, 1'b0);
    chk("ovf_sticky", ovf_err, 2'b01);

    // Reset with both FIFOs partly full and pushes pending flushes everything.
    cycle(0, 1, mk_beat(50, 8'hFF, 9'd50), 1, mk_beat(60, 8'hFF, 9'd60), 0);
    cycle(0, 1, mk_beat(51, 8'hFF, 9'd51), 1, mk_beat(61, 8'hFF, 9'd61), 0);
    cycle(0, 1, mk_beat(52, 8'hFF, 9'd52), 0, zb, 0);
    cycle(1, 1, mk_beat(53, 8'hFF, 9'd53), 1, mk_beat(62, 8'hFF, 9'd62), 0);
    chk("rst_pre_acnt", a_cnt, 3);
    chk("rst_pre_bcnt", b_cnt, 2);
    cycle(0, 0, zb, 0, zb, 0);
    chk("rst_acnt", a_cnt, 0);
    chk("rst_bcnt", b_cnt, 0);
    chk("rst_pvld", dst_pvld, 1'b0);
    chk("rst_ovf", ovf_err, 2'b00);

    // Full FIFO pushed while popping: accepted, occupancy unchanged, no error.
    for (int i = 0; i < 4; i++) cycle(0, 1, mk_beat(30 + i, 8'hFF, 9'(30 + i)), 0, zb, 0);
    cycle(0, 1, mk_beat(34, 8'hFF, 9'd34), 0, zb, 1);
    chk("full_pp_pre", a_cnt, 4);
    cycle(0, 0, zb, 0, zb, 0);
    chk("full_pp_acnt", a_cnt, 4);
    chk("full_pp_ovf", ovf_err, 2'b00);
    chk("full_pp_head", dst_pd, 9'd31);

    // Stalled grant on B must stay on B while A fills, then A is next.
    cycle(1, 0, zb, 0, zb, 0);
    cycle(0, 0, zb, 1, mk_beat(40, 8'hA5, 9'd40), 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, mk_beat(41 + i, 8'hFF, 9'(41 + i)), 0, zb, 0);
      chk($sformatf("hold_src%0d", i), dst_src, 1'b1);
      chk($sformatf("hold_pd%0d", i),  dst_pd,  9'd40);
    end
    cycle(0, 0, zb, 0, zb, 1);
    cycle(0, 0, zb, 0, zb, 1);
    chk("hold_next_src", dst_src, 1'b0);
    chk("hold_next_pd",  dst_pd,  9'd41);

    // Random traffic against the queue model.
    cycle(1, 0, zb, 0, zb, 0);
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 299) == 0,
            $urandom_range(0, 99) < 55, rand_beat(),
            $urandom_range(0, 99) < 55, rand_beat(),
            $urandom_range(0, 99) < 65);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
